// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, pixel/state types and the BRAM address packer
// for the 128x128x12-bit BGR write engine.
package fb_pkg;

   localparam int FB_W  = 128;
   localparam int FB_H  = 128;
   localparam int AW    = 14;
   localparam int DW    = 12;
   localparam int COORD = 7;

   typedef logic [DW-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_STREAM   = 2'd2,
      ST_FILL     = 2'd3
   } state_t;

   // FB_W is a power of two, so row*FB_W+col is a plain concatenation.
   function automatic logic [AW-1:0] pack_addr(input logic [COORD-1:0] row,
                                               input logic [COORD-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/bram_pixel_writer_if.sv
// Raster pixel stream into the frame-buffer writer. A beat transfers on a rising
// edge where s_valid && s_ready; s_ready never depends on s_valid.
interface bram_pixel_writer_if;

   logic                    s_valid;
   logic                    s_ready;
   logic [fb_pkg::DW-1:0]   s_data;
   logic                    s_sof;

   modport master (output s_valid, output s_data, output s_sof, input s_ready);
   modport slave  (input s_valid, input s_data, input s_sof, output s_ready);

endinterface

// File: rtl/fb_window_scan.sv
// Column/row walker over the latched window: emits the address and last-pixel
// flag for the current (or origin) position and advances in raster order.
module fb_window_scan
   import fb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [COORD-1:0] x0,
   input  logic [COORD-1:0] y0,
   input  logic [7:0]       w,
   input  logic [7:0]       h,
   input  logic             advance,
   input  logic             from_origin,
   output logic [AW-1:0]    addr,
   output logic             last
);

   logic [COORD-1:0] x0_q, y0_q;
   logic [7:0]       w_q, h_q;
   logic [7:0]       c_q, r_q;
   logic [7:0]       c_d, r_d;
   logic [7:0]       pos_c, pos_r;
   logic             col_end;

   // from_origin lets a start-of-frame beat be addressed at (0,0) this cycle.
   always_comb begin
      pos_c   = from_origin ? 8'd0 : c_q;
      pos_r   = from_origin ? 8'd0 : r_q;
      col_end = (pos_c == (w_q - 8'd1));
      last    = col_end && (pos_r == (h_q - 8'd1));
      addr    = pack_addr(y0_q + pos_r[COORD-1:0], x0_q + pos_c[COORD-1:0]);
      if (col_end) begin
         c_d = 8'd0;
         r_d = pos_r + 8'd1;
      end else begin
         c_d = pos_c + 8'd1;
         r_d = pos_r;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_q <= '0;
         y0_q <= '0;
         w_q  <= '0;
         h_q  <= '0;
         c_q  <= '0;
         r_q  <= '0;
      end else if (load) begin
         x0_q <= x0;
         y0_q <= y0;
         w_q  <= w;
         h_q  <= h;
         c_q  <= '0;
         r_q  <= '0;
      end else if (advance) begin
         c_q  <= c_d;
         r_q  <= r_d;
      end
   end

endmodule

// File: rtl/bram_pixel_writer.sv
// Write-side engine for the frame buffer: turns a raster stream or a solid fill
// into registered BRAM writes confined to a validated rectangular window.
module bram_pixel_writer
   import fb_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [COORD-1:0]     win_x0,
   input  logic [COORD-1:0]     win_y0,
   input  logic [7:0]           win_w,
   input  logic [7:0]           win_h,
   input  logic                 start,
   input  logic                 fill,
   input  pixel_t               fill_color,
   bram_pixel_writer_if.slave   s,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output pixel_t               wr_data,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 sof_err,
   output logic                 cfg_err,
   output state_t               dbg_state
);

   state_t          state_q, state_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   pixel_t          wr_data_q, wr_data_d;
   pixel_t          fill_color_q, fill_color_d;
   logic            frame_done_q, frame_done_d;
   logic            sof_err_q, sof_err_d;
   logic            cfg_err_q, cfg_err_d;

   logic            scan_load, scan_advance, scan_from_origin;
   logic [AW-1:0]   scan_addr;
   logic            scan_last;
   logic            accept;
   logic            win_bad;
   logic [8:0]      x_end, y_end;

   fb_window_scan u_scan (
      .clk         (clk),
      .reset       (reset),
      .load        (scan_load),
      .x0          (win_x0),
      .y0          (win_y0),
      .w           (win_w),
      .h           (win_h),
      .advance     (scan_advance),
      .from_origin (scan_from_origin),
      .addr        (scan_addr),
      .last        (scan_last)
   );

   assign s.s_ready = (state_q == ST_WAIT_SOF) || (state_q == ST_STREAM);
   assign accept    = s.s_valid && s.s_ready;

   // 9-bit sums so x0+w = 128 is legal and anything beyond is caught.
   assign x_end   = {2'b00, win_x0} + {1'b0, win_w};
   assign y_end   = {2'b00, win_y0} + {1'b0, win_h};
   assign win_bad = (win_w == 8'd0) || (win_h == 8'd0) ||
                    (x_end > 9'd128) || (y_end > 9'd128);

   always_comb begin
      state_d          = state_q;
      scan_load        = 1'b0;
      scan_advance     = 1'b0;
      scan_from_origin = 1'b0;
      wr_en_d          = 1'b0;
      wr_addr_d        = wr_addr_q;
      wr_data_d        = wr_data_q;
      fill_color_d     = fill_color_q;
      frame_done_d     = 1'b0;
      sof_err_d        = 1'b0;
      cfg_err_d        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (fill || start) begin
               if (win_bad) begin
                  cfg_err_d = 1'b1;
               end else begin
                  scan_load = 1'b1;
                  if (fill) begin
                     fill_color_d = fill_color;
                     state_d      = ST_FILL;
                  end else begin
                     state_d      = ST_WAIT_SOF;
                  end
               end
            end
         end

         ST_WAIT_SOF: begin
            if (accept && s.s_sof) begin
               scan_advance     = 1'b1;
               scan_from_origin = 1'b1;
               wr_en_d          = 1'b1;
               wr_addr_d        = scan_addr;
               wr_data_d        = s.s_data;
               frame_done_d     = scan_last;
               state_d          = scan_last ? ST_IDLE : ST_STREAM;
            end
         end

         ST_STREAM: begin
            if (accept) begin
               // A stray start-of-frame restarts the window at its origin.
               scan_advance     = 1'b1;
               scan_from_origin = s.s_sof;
               sof_err_d        = s.s_sof;
               wr_en_d          = 1'b1;
               wr_addr_d        = scan_addr;
               wr_data_d        = s.s_data;
               frame_done_d     = scan_last;
               if (scan_last) state_d = ST_IDLE;
            end
         end

         ST_FILL: begin
            scan_advance = 1'b1;
            wr_en_d      = 1'b1;
            wr_addr_d    = scan_addr;
            wr_data_d    = fill_color_q;
            frame_done_d = scan_last;
            if (scan_last) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         fill_color_q <= '0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         fill_color_q <= fill_color_d;
         frame_done_q <= frame_done_d;
         sof_err_q    <= sof_err_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign sof_err    = sof_err_q;
   assign cfg_err    = cfg_err_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_bram_pixel_writer.sv
// Directed bench for bram_pixel_writer: every BRAM write is matched against a
// queue of hand-computed {sof_err, frame_done, addr, data} words.
module tb_bram_pixel_writer;
   import fb_pkg::*;

   localparam int EXP_W = 28;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    win_x0, win_y0;
   logic [7:0]    win_w, win_h;
   logic          start, fill;
   logic [11:0]   fill_color;
   logic          wr_en, busy, frame_done, sof_err, cfg_err;
   logic [13:0]   wr_addr;
   logic [11:0]   wr_data;
   state_t        dbg_state;

   bram_pixel_writer_if s_if ();

   bram_pixel_writer dut (
      .clk        (clk),
      .reset      (reset),
      .win_x0     (win_x0),
      .win_y0     (win_y0),
      .win_w      (win_w),
      .win_h      (win_h),
      .start      (start),
      .fill       (fill),
      .fill_color (fill_color),
      .s          (s_if.slave),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .frame_done (frame_done),
      .sof_err    (sof_err),
      .cfg_err    (cfg_err),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [EXP_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [EXP_W-1:0] mk(input logic se, input logic fd,
                                          input logic [13:0] a, input logic [11:0] d);
      return {se, fd, a, d};
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_en) begin
            if (exp_q.size() == 0) check("spurious_wr", {18'd0, wr_addr}, 32'hFFFF_FFFF);
            else check("wr_word", {4'd0, sof_err, frame_done, wr_addr, wr_data}, {4'd0, exp_q.pop_front()});
         end else if (frame_done || sof_err) begin
            check("pulse_without_wr", {30'd0, sof_err, frame_done}, 32'd0);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic do_reset();
      reset = 1'b1; start = 0; fill = 0;
      win_x0 = 0; win_y0 = 0; win_w = 0; win_h = 0; fill_color = 0;
      s_if.s_valid = 0; s_if.s_data = 0; s_if.s_sof = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic cmd(input logic st, input logic fl, input logic [6:0] x0, input logic [6:0] y0,
                      input logic [7:0] w, input logic [7:0] h, input logic [11:0] col);
      @(posedge clk); #1;
      start = st; fill = fl; win_x0 = x0; win_y0 = y0; win_w = w; win_h = h; fill_color = col;
      @(posedge clk); #1;
      start = 0; fill = 0;
   endtask

   task automatic send_beat(input logic [11:0] d, input logic sof);
      bit done = 0;
      s_if.s_valid = 1'b1; s_if.s_data = d; s_if.s_sof = sof;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (s_if.s_ready) begin
            @(posedge clk); #1;
            done = 1;
         end
      end
      if (!done) check("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_stream();
      s_if.s_valid = 1'b0; s_if.s_sof = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit done = 0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk); #1;
         if (!busy && exp_q.size() == 0) done = 1;
      end
      if (!done) check("drain_timeout", {31'd0, busy}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      @(negedge clk);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, s_if.s_ready}, 32'd0);
      check("rst_addr", {18'd0, wr_addr}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

      // 3x2 window at (10,20): row 20 -> 2570.., row 21 -> 2698..
      exp_q.push_back(mk(0, 0, 14'd2570, 12'd1));
      exp_q.push_back(mk(0, 0, 14'd2571, 12'd2));
      exp_q.push_back(mk(0, 0, 14'd2572, 12'd3));
      exp_q.push_back(mk(0, 0, 14'd2698, 12'd4));
      exp_q.push_back(mk(0, 0, 14'd2699, 12'd5));
      exp_q.push_back(mk(0, 1, 14'd2700, 12'd6));
      cmd(1, 0, 7'd10, 7'd20, 8'd3, 8'd2, 12'd0);
      for (int i = 1; i <= 6; i++) send_beat(12'(i), i == 1);
      idle_stream();
      wait_done(20);
      check("small_busy_after", {31'd0, busy}, 32'd0);

      // full frame, back-to-back beats
      for (int i = 0; i < 16384; i++) exp_q.push_back(mk(0, i == 16383, 14'(i), 12'(i)));
      cmd(1, 0, 7'd0, 7'd0, 8'd128, 8'd128, 12'd0);
      for (int i = 0; i < 16384; i++) send_beat(12'(i), i == 0);
      idle_stream();
      wait_done(20);
      check("full_busy_after", {31'd0, busy}, 32'd0);

      // WAIT_SOF discards non-sof beats; gaps give no writes. Origin (5,7) -> 901
      cmd(1, 0, 7'd5, 7'd7, 8'd2, 8'd1, 12'd0);
      for (int i = 0; i < 5; i++) send_beat(12'h111 + 12'(i), 1'b0);
      idle_stream();
      @(negedge clk);
      check("discard_state", {30'd0, dbg_state}, {30'd0, ST_WAIT_SOF});
      check("discard_ready", {31'd0, s_if.s_ready}, 32'd1);
      exp_q.push_back(mk(0, 0, 14'd901, 12'hABC));
      exp_q.push_back(mk(0, 1, 14'd902, 12'h123));
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1 send_beat(12'hABC, 1'b1);
      idle_stream();
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1 send_beat(12'h123, 1'b0);
      idle_stream();
      wait_done(20);

      // solid fill 8x8 at (120,120): 15480 .. 16383
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            exp_q.push_back(mk(0, (r == 7) && (c == 7), 14'((120 + r) * 128 + 120 + c), 12'h0F0));
      cmd(0, 1, 7'd120, 7'd120, 8'd8, 8'd8, 12'h0F0);
      begin
         bit seen = 0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (wr_en) seen = 1;
         end
         check("fill_started", {31'd0, seen}, 32'd1);
         check("fill_ready0", {31'd0, s_if.s_ready}, 32'd0);
         for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            check("fill_consec", {30'd0, s_if.s_ready, wr_en}, 32'd1);
         end
      end
      wait_done(10);

      // illegal window: 100+40 > 128, then zero width via fill
      cmd(1, 0, 7'd100, 7'd0, 8'd40, 8'd1, 12'd0);
      @(negedge clk);
      check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
      check("cfg_err_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("cfg_err_single", {31'd0, cfg_err}, 32'd0);
      cmd(0, 1, 7'd0, 7'd0, 8'd0, 8'd4, 12'h111);
      @(negedge clk);
      check("cfg_err_w0", {31'd0, cfg_err}, 32'd1);
      check("cfg_err_w0_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

      // start and fill together: fill wins
      exp_q.push_back(mk(0, 0, 14'd0, 12'h777));
      exp_q.push_back(mk(0, 1, 14'd1, 12'h777));
      cmd(1, 1, 7'd0, 7'd0, 8'd2, 8'd1, 12'h777);
      @(negedge clk);
      check("both_takes_fill", {30'd0, dbg_state}, {30'd0, ST_FILL});
      wait_done(10);

      // mid-frame sof on 4th beat of a 3x2 window at (1,1): origin 129
      exp_q.push_back(mk(0, 0, 14'd129, 12'h101));
      exp_q.push_back(mk(0, 0, 14'd130, 12'h102));
      exp_q.push_back(mk(0, 0, 14'd131, 12'h103));
      exp_q.push_back(mk(1, 0, 14'd129, 12'h104));
      exp_q.push_back(mk(0, 0, 14'd130, 12'h105));
      exp_q.push_back(mk(0, 0, 14'd131, 12'h106));
      exp_q.push_back(mk(0, 0, 14'd257, 12'h107));
      exp_q.push_back(mk(0, 0, 14'd258, 12'h108));
      exp_q.push_back(mk(0, 1, 14'd259, 12'h109));
      cmd(1, 0, 7'd1, 7'd1, 8'd3, 8'd2, 12'd0);
      for (int i = 1; i <= 9; i++) send_beat(12'h100 + 12'(i), (i == 1) || (i == 4));
      idle_stream();
      wait_done(20);

      // 1x1 window at the last pixel: frame_done straight from WAIT_SOF
      exp_q.push_back(mk(0, 1, 14'd16383, 12'h5A5));
      cmd(1, 0, 7'd127, 7'd127, 8'd1, 8'd1, 12'd0);
      send_beat(12'h5A5, 1'b1);
      idle_stream();
      @(negedge clk); #1;
      check("one_px_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      wait_done(10);

      // asynchronous reset in the middle of a full-frame fill
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 0, 14'(i), 12'h3C3));
      cmd(0, 1, 7'd0, 7'd0, 8'd128, 8'd128, 12'h3C3);
      begin
         bit drained = 0;
         for (int k = 0; k < 20 && !drained; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) drained = 1;
         end
         check("fill_pre_reset", {31'd0, drained}, 32'd1);
      end
      reset = 1'b1;
      #1;
      check("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      @(posedge clk); #1 reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("post_rst_addr", {18'd0, wr_addr}, 32'd0);
      check("leftover_exp", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bram_pixel_writer.md
Name: bram_pixel_writer

Overview:
Write-side engine for the 128x128x12-bit BGR frame buffer. It takes a raster pixel stream over a valid/ready handshake, or a solid-colour fill command, and turns it into BRAM write-port transactions (enable, address, data) confined to a programmable rectangular window. It sits between pixel producers (camera/test-pattern/CPU bridge) and the buffer's write port; the VGA read side is unaffected.

Parameters:
FB_W, 128, frame buffer width in pixels (power of two)
FB_H, 128, frame buffer height in pixels
AW, 14, write address width, log2(FB_W*FB_H)
DW, 12, pixel width, 4-bit x 3 BGR

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous active-high reset
win_x0  in  7  window left column, sampled on command accept
win_y0  in  7  window top row, sampled on command accept
win_w  in  8  window width 1..128, sampled on command accept
win_h  in  8  window height 1..128, sampled on command accept
start  in  1  arm stream capture into window (level, sampled in IDLE)
fill  in  1  start solid fill of window (level, sampled in IDLE)
fill_color  in  12  fill pixel value, sampled on command accept
s_valid  in  1  stream beat valid
s_ready  out  1  stream beat accepted when s_valid & s_ready
s_data  in  12  stream pixel
s_sof  in  1  beat is first pixel of a frame
wr_en  out  1  BRAM write enable
wr_addr  out  14  BRAM write address, row*128+col
wr_data  out  12  BRAM write data
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse coincident with last window write
sof_err  out  1  one-cycle pulse: sof on a beat mid-frame
cfg_err  out  1  one-cycle pulse: command rejected for bad window

Behaviour:
- Reset (async, any time incl. mid-frame/mid-fill): state IDLE, counters 0, all outputs 0; a partial frame is abandoned, no further writes.
- States: IDLE, WAIT_SOF, STREAM, FILL.
- IDLE: s_ready=0. fill=1 -> validate, latch window+fill_color, go FILL. Else start=1 -> validate, latch window, go WAIT_SOF. fill and start together: fill wins, start dropped.
- Validation: win_w==0, win_h==0, x0+w>128 or y0+h>128 (9-bit compare) -> cfg_err pulse next cycle, stay IDLE, no writes.
- Commands outside IDLE are ignored (no error).
- WAIT_SOF: s_ready=1; beats without s_sof are consumed and discarded; beat with s_sof is written at (x0,y0), counters c=1/r=0 (or advanced per wrap rules for w=1), go STREAM.
- STREAM: s_ready=1; every accepted beat writes at (y0+r, x0+c). c increments; at c==w-1 wraps to 0 and r increments. Write of (r=h-1,c=w-1) asserts frame_done with wr_en; next state IDLE. If the first beat is also last (1x1 window), frame_done on that write and back to IDLE from WAIT_SOF.
- s_sof on an accepted beat in STREAM: sof_err pulse with that write; beat written at origin, counters resync as a new first pixel; frame continues.
- s_ready depends only on state (never on s_valid). Throughput 1 pixel/cycle.
- FILL: s_ready=0; one write per cycle over the window in raster order, wr_data=fill_color; exactly w*h writes; frame_done on last; then IDLE.
- Latency: accepted beat at edge N -> wr_en/wr_addr/wr_data registered, valid cycle after edge N. FILL first write is the cycle after the accept edge.
- Outputs wr_* registered; wr_en=0 whenever no write, wr_addr/wr_data hold last value.
- Address: {row[6:0], col[6:0]} (row*128+col via concatenation, no multiplier); row=y0+r and col=x0+c in 7 bits, never overflow after validation.
- busy=1 in WAIT_SOF, STREAM, FILL.

Decomposition:
- Package fb_pkg: FB_W, FB_H, AW, DW, pixel typedef, state enum, address-pack function {row,col}.
- One sub-module natural: fb_window_scan (c/r counters, wrap, last-pixel flag, address generation), shared by STREAM (advance on accept) and FILL (advance every cycle).

Test Plan:
- Full window x0=y0=0,w=h=128, 16384 beats with sof on first, s_valid always 1 -> 16384 writes, addr 0..16383 in order, frame_done with addr 16383, then busy=0.
- Window x0=10,y0=20,w=3,h=2, data 1..6 -> addrs 2570,2571,2572,2698,2699,2700 carrying 1..6; frame_done on 6th.
- WAIT_SOF discard: 5 beats without sof then sof beat 0xABC -> first write only 0xABC at origin; s_valid gaps of random length -> no spurious wr_en.
- fill=1, x0=y0=120,w=h=8, color 0x0F0 -> 64 consecutive writes, addr 15480..16383 window rows, s_ready=0 throughout, frame_done on 64th.
- Bad window x0=100,w=40 with start -> cfg_err pulse, busy stays 0; start+fill together -> FILL taken.
- Mid-frame s_sof on 4th beat of 3x2 window -> sof_err, 4th beat to origin, 5 more beats complete frame; reset asserted mid-FILL -> wr_en=0 and IDLE immediately (async).
